spi_4_byte_transmitter: RTL
===========================

# spi_4_byte_transmitter

SPI controller that shifts a 32-bit word out on MOSI as four bytes, most significant byte first, while capturing four bytes from MISO. It is the initiating end of the link whose peripheral side is the 4-byte receiver: it generates `ss`, `sck` and `mosi` from the system clock. An optional idle gap between bytes gives the peripheral time to act on each received byte. Host logic loads a word with a one-cycle `start` strobe and waits for `done`.

## Interface
- `CLK_DIV`, 4: `sck` half-period in `clk` cycles; legal range is 1 or more.
- `GAP_CYCLES`, 8: idle `clk` cycles between bytes, with `sck` low and `ss` held low; 0 means no gap.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `din`  in  32  word to send; sampled in the cycle `start` is accepted.
- `miso`  in  1  serial data from the peripheral.
- `ss`  out  1  active-low chip select.
- `sck`  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- `mosi`  out  1  serial data to the peripheral.
- `busy`  out  1  high from the cycle after start acceptance until `done`, inclusive.
- `done`  out  1  one-cycle pulse when the transfer is complete.
- `dout`  out  32  word captured from MISO; first byte received is in `[31:24]`.

## Operation
- Reset values: `ss`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `dout`=0. All counters and shift registers are cleared.
- States:
  - IDLE: no transfer.
  - LOW: `sck` low phase.
  - HIGH: `sck` high phase.
  - GAP: idle time between bytes.
  - HOLD: `ss` hold time after the last bit.
- IDLE → LOW when `start`=1:
  - Load `din` into the TX shift register.
  - Drive `ss`←0, `mosi`←`din[31]`, `busy`←1.
  - Clear the bit counter (0–7) and byte counter (0–3).
- LOW: `sck`=0 for CLK_DIV cycles. On exit, `sck`←1 and `miso` is shifted into the LSB of the RX shift register. Next state is HIGH.
- HIGH: `sck`=1 for CLK_DIV cycles. On exit, `sck`←0 and one of the following applies:
  - Bit counter < 7: advance `mosi` to the next bit; go to LOW.
  - Bit counter = 7, byte counter < 3: present the next byte's MSB on `mosi`; go to GAP, or directly to LOW if GAP_CYCLES=0.
  - Bit counter = 7, byte counter = 3: go to HOLD.
- GAP: hold for GAP_CYCLES cycles, then go to LOW.
- HOLD: hold for CLK_DIV cycles with `sck`=0. On exit:
  - Drive `ss`←1 and `mosi`←0.
  - Assert `done` for one cycle and load `dout` from the RX shift register.
  - Keep `busy`=1 in that cycle, then return to IDLE with `busy`=0.
- Bit order: MSB first within each byte; bytes are sent `din[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
- `mosi` changes only on `sck` falling transitions or at start. It is stable for the full CLK_DIV cycles before every rising edge.
- `start` while `busy`=1 is ignored. The in-flight word is not disturbed, and later changes to `din` have no effect.
- `rst` mid-transfer aborts immediately to reset values: `ss` rises in the cycle after `rst` is sampled, and no `done` is produced.
- `start` and `rst` asserted together: reset wins.
- `dout` changes only at `done`; it holds its value between transfers.

## Timing
- The cycle in which `start` is sampled is cycle 0. `ss`=0 and `mosi`=`din[31]` from cycle 1.
- Rising edge of bit k within byte b occurs at cycle 1 + CLK_DIV·(2·(8b+k)+1) + b·GAP_CYCLES.
- `done` is high in cycle 1 + 65·CLK_DIV + 3·GAP_CYCLES. With the defaults this is cycle 285. `ss` returns to 1 in the same cycle.
- Back-to-back transfers: the earliest next `start` accepted is in the cycle after `done`, so minimum `ss`-high time is 1 cycle.
- With CLK_DIV=1, `sck` toggles every cycle (`clk`/2) and all rules above still hold.

## Test plan
- Defaults, `din`=32'hA5C3_0F81, `miso` looped back from `mosi`:
  - Bench SPI-mode-0 monitor decodes bytes A5, C3, 0F, 81 in that order.
  - `done` occurs in cycle 285; `dout`=32'hA5C3_0F81.
- `miso` driven from a peripheral model returning 8'h12, 34, 56, 78 → `dout`=32'h1234_5678. Each gap measures 8 cycles with `sck`=0 and `ss`=0.
- CLK_DIV=1, GAP_CYCLES=0, `din`=32'hFFFF_0000:
  - 64 consecutive `sck` toggles with no idle.
  - `done` in cycle 66.
  - `mosi` is high for the first 16 rising edges and low for the last 16.
- `start` re-pulsed at cycle 50 with a different `din` → ignored; the original word completes unchanged. A `start` in the cycle after `done` is accepted.
- `rst` at cycle 100 of a transfer:
  - Cycle 101 shows `ss`=1, `sck`=0, `busy`=0, `dout`=0.
  - No `done` appears.
  - A following `start` sends a correct full word.
- `start` and `rst` asserted in the same cycle → no transfer begins; `ss` stays 1.

Source files
------------

// File: rtl/spi_4_byte_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_4_byte_transmitter_if
// Description : Host handshake and SPI pin bundle for the 4-byte SPI
//               transmitter. The master modport is the controller's view;
//               the slave modport is the view of the host/peripheral side.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_4_byte_transmitter_if;

  // Host side: transfer request and data word
  logic        start;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  // SPI pins
  logic        miso;
  logic        ss;
  logic        sck;
  logic        mosi;

  // Controller view: takes requests and MISO, drives the link and status
  modport master (
    input  start,
    input  din,
    input  miso,
    output ss,
    output sck,
    output mosi,
    output busy,
    output done,
    output dout
  );

  // Host/peripheral view: issues requests and MISO, observes everything else
  modport slave (
    output start,
    output din,
    output miso,
    input  ss,
    input  sck,
    input  mosi,
    input  busy,
    input  done,
    input  dout
  );

endinterface : spi_4_byte_transmitter_if
`default_nettype wire

// File: rtl/spi_4_byte_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : spi_4_byte_transmitter
// Description : SPI mode-0 controller. Shifts a 32-bit word out on MOSI as
//               four MSB-first bytes (most significant byte first) while
//               capturing four bytes from MISO. An optional idle gap is
//               inserted between bytes; chip select is held for one sck
//               half-period after the last bit before the transfer completes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_4_byte_transmitter #(
  parameter int CLK_DIV    = 4,   // sck half-period in clk cycles, >= 1
  parameter int GAP_CYCLES = 8    // idle clk cycles between bytes, 0 = none
) (
  input  wire logic               clk,
  input  wire logic               rst,
  spi_4_byte_transmitter_if.master bus
);

  // One shared phase counter serves the LOW, HIGH, GAP and HOLD states, so it
  // is sized for the longer of the two programmable durations.
  localparam int MAX_COUNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  localparam logic [CW-1:0] C_DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_GAP_LAST = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic          C_HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,   // no transfer in progress
    S_LOW  = 3'd1,   // sck low phase, mosi stable
    S_HIGH = 3'd2,   // sck high phase
    S_GAP  = 3'd3,   // idle time between bytes
    S_HOLD = 3'd4    // ss hold time after the last bit
  } state_t;

  state_t          state;
  logic [CW-1:0]   phase_cnt;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [31:0]     tx_shift;
  logic [31:0]     rx_shift;

  logic            ss_q;
  logic            sck_q;
  logic            mosi_q;
  logic            busy_q;
  logic            done_q;
  logic [31:0]     dout_q;

  // All link and status outputs come straight from registers
  assign bus.ss   = ss_q;
  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;

  // Transfer sequencer: phase timing, shifting and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      ss_q      <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= '0;
    end else begin
      done_q <= 1'b0;

      case (state)
        S_IDLE: begin
          // busy is still high in the done cycle; a start seen then is
          // ignored so the earliest accepted start is the following cycle
          if (bus.start && !busy_q) begin
            state     <= S_LOW;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            tx_shift  <= bus.din;
            rx_shift  <= '0;
            ss_q      <= 1'b0;
            mosi_q    <= bus.din[31];
            busy_q    <= 1'b1;
          end else begin
            busy_q    <= 1'b0;
          end
        end

        S_LOW: begin
          // Rising sck edge: capture MISO while MOSI has been stable all phase
          if (phase_cnt == C_DIV_LAST) begin
            phase_cnt <= '0;
            sck_q     <= 1'b1;
            rx_shift  <= {rx_shift[30:0], bus.miso};
            state     <= S_HIGH;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        S_HIGH: begin
          // Falling sck edge: the only place MOSI advances mid-transfer
          if (phase_cnt == C_DIV_LAST) begin
            phase_cnt <= '0;
            sck_q     <= 1'b0;
            bit_cnt   <= bit_cnt + 1'b1;
            tx_shift  <= {tx_shift[30:0], 1'b0};
            if (bit_cnt != 3'd7) begin
              mosi_q <= tx_shift[30];
              state  <= S_LOW;
            end else if (byte_cnt != 2'd3) begin
              // Next byte's MSB goes out now so it is stable through the gap
              mosi_q   <= tx_shift[30];
              byte_cnt <= byte_cnt + 1'b1;
              state    <= C_HAS_GAP ? S_GAP : S_LOW;
            end else begin
              state    <= S_HOLD;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        S_GAP: begin
          // Inter-byte idle: sck low, ss low, mosi already on the next MSB
          if (phase_cnt == C_GAP_LAST) begin
            phase_cnt <= '0;
            state     <= S_LOW;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          // Release the link and publish the captured word
          if (phase_cnt == C_DIV_LAST) begin
            phase_cnt <= '0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b1;
            dout_q    <= rx_shift;
            state     <= S_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : spi_4_byte_transmitter
`default_nettype wire
